// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL by 0..WIDTH-1 over SHW elastic stages.
// Stage k applies a shift of 2^k when its amount bit is set; full valid/ready backpressure.
module shift_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  logic [SHW:0]     adv;        // adv[k]: stage k may load this cycle
  logic [SHW-1:0]   valid_vec;
  logic [WIDTH-1:0] last_nxt;   // shifted data entering the final stage
  logic             zero_q;

  // A stage advances when it is empty or the stage after it advances, so
  // bubbles are squeezed out even while the output is stalled.
  always_comb begin
    adv[SHW] = out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      adv[k] = !valid_vec[k] | adv[k+1];
    end
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int S  = 1 << k;
    localparam int AW = SHW - k;   // amount bits still unconsumed at this stage's input

    logic             sv;
    logic             sc;
    logic [WIDTH-1:0] sd;
    logic [AW-1:0]    sa;
    logic [1:0]       so;

    logic [WIDTH-1:0] nd;
    logic             nc;

    logic             valid_q;
    logic             carry_q;
    logic [WIDTH-1:0] data_q;

    if (k == 0) begin : g_src
      assign sv = in_valid;
      assign sd = in_data;
      assign sa = in_amt;
      assign so = in_op;
      assign sc = 1'b0;
    end else begin : g_src
      assign sv = g_stage[k-1].valid_q;
      assign sd = g_stage[k-1].data_q;
      assign sa = g_stage[k-1].g_fwd.amt_q;
      assign so = g_stage[k-1].g_fwd.op_q;
      assign sc = g_stage[k-1].carry_q;
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/case can leave it unassigned and infer a latch.
    always_comb begin
      nd = sd;
      nc = sc;
      if (sa[0]) begin
        case (op_e'(so))
          OP_SLL: begin
            nd = sd << S;
            nc = sd[WIDTH-S];
          end
          OP_SRL: begin
            nd = sd >> S;
            nc = sd[S-1];
          end
          OP_SRA: begin
            nd = WIDTH'($signed(sd) >>> S);
            nc = sd[S-1];
          end
          OP_ROL: begin
            nd = {sd[WIDTH-S-1:0], sd[WIDTH-1:WIDTH-S]};
            nc = sd[WIDTH-S];
          end
        endcase
      end
    end

    // NOTE: state registers use non-blocking assignments so every stage samples
    // its upstream neighbour's pre-edge value, regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        carry_q <= 1'b0;
      end else if (adv[k]) begin
        valid_q <= sv;
        data_q  <= nd;
        carry_q <= nc;
      end
    end

    assign valid_vec[k] = valid_q;

    // Bit 0 of the amount is consumed here, so only the higher bits travel on.
    if (k < SHW - 1) begin : g_fwd
      logic [AW-2:0] amt_q;
      logic [1:0]    op_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amt_q <= '0;
          op_q  <= '0;
        end else if (adv[k]) begin
          amt_q <= sa[AW-1:1];
          op_q  <= so;
        end
      end
    end else begin : g_out
      assign last_nxt  = nd;
      assign out_valid = valid_q;
      assign out_data  = data_q;
      assign out_carry = carry_q;
    end
  end

  // Zero flag is registered with the last stage so it holds with out_data on a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b1;
    end else if (adv[SHW-1]) begin
      zero_q <= (last_nxt == '0);
    end
  end

  assign out_zero = zero_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed ops, random throughput and backpressure
// runs against a queue-based reference model, plus reset and bubble-collapse scenarios.
module tb_shift_pipe;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero)
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             zero;
  } res_t;

  int   total = 0;
  int   bad   = 0;
  res_t exp_q[$];

  logic             s_in_ready, s_out_valid, s_out_carry, s_out_zero, s_acc, s_fire;
  logic [WIDTH-1:0] s_out_data;

  // Whole-amount reference: one shift by a, carry is the last bit that left.
  function automatic res_t model(input logic [WIDTH-1:0] d, input int a, input logic [1:0] o);
    res_t             r;
    logic [WIDTH-1:0] v;
    logic             c;
    case (o)
      2'd0: begin v = d << a; c = (a == 0) ? 1'b0 : d[WIDTH-a]; end
      2'd1: begin v = d >> a; c = (a == 0) ? 1'b0 : d[a-1]; end
      2'd2: begin v = WIDTH'($signed(d) >>> a); c = (a == 0) ? 1'b0 : d[a-1]; end
      default: begin
        v = (a == 0) ? d : ((d << a) | (d >> (WIDTH - a)));
        c = (a == 0) ? 1'b0 : v[0];
      end
    endcase
    r.data  = v;
    r.carry = c;
    r.zero  = (v == '0);
    return r;
  endfunction

  // Called at a falling edge: drive, sample, record accepted ops, step one cycle.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic [SHW-1:0] a,
                       input logic [1:0] o, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_amt    = a;
    in_op     = o;
    out_ready = ordy;
    #1;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_out_carry = out_carry;
    s_out_zero  = out_zero;
    s_acc       = v && in_ready;
    s_fire      = out_valid && ordy;
    if (s_acc) exp_q.push_back(model(d, int'(a), o));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, $urandom, SHW'($urandom), 2'($urandom), ordy);
  endtask

  task automatic rand_op(input logic ordy);
    cycle(1'b1, $urandom, SHW'($urandom), 2'($urandom), ordy);
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = '0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({out_valid, out_data, out_carry, out_zero} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: got v=%0b d=%h c=%0b z=%0b want 0/0/0/1",
               out_valid, out_data, out_carry, out_zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) rand_op(1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_zero !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid: got v=%0b z=%0b want v=0 z=1", out_valid, out_zero);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
    total++;
    if (s_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %0b want 1", s_in_ready);
    end
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      total++;
      if (s_out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_stale: cycle %0d got out_valid=%0b want 0", i, s_out_valid);
      end
    end
  endtask

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [SHW-1:0]   a;
    logic [1:0]       o;
    logic [WIDTH-1:0] r;
    logic             c;
  } vec_t;

  task automatic test_basic;
    vec_t vecs[12];
    vecs[0]  = '{32'h80000001, 5'd1,  2'd0, 32'h00000002, 1'b1};
    vecs[1]  = '{32'h80000001, 5'd1,  2'd1, 32'h40000000, 1'b1};
    vecs[2]  = '{32'h80000001, 5'd1,  2'd2, 32'hC0000000, 1'b1};
    vecs[3]  = '{32'h80000001, 5'd1,  2'd3, 32'h00000003, 1'b1};
    vecs[4]  = '{32'h80000000, 5'd31, 2'd2, 32'hFFFFFFFF, 1'b0};
    vecs[5]  = '{32'h00000001, 5'd31, 2'd0, 32'h80000000, 1'b0};
    vecs[6]  = '{32'h12345678, 5'd0,  2'd0, 32'h12345678, 1'b0};
    vecs[7]  = '{32'h12345678, 5'd0,  2'd1, 32'h12345678, 1'b0};
    vecs[8]  = '{32'h12345678, 5'd0,  2'd2, 32'h12345678, 1'b0};
    vecs[9]  = '{32'h12345678, 5'd0,  2'd3, 32'h12345678, 1'b0};
    vecs[10] = '{32'h00000001, 5'd1,  2'd1, 32'h00000000, 1'b1};
    vecs[11] = '{32'h00000003, 5'd31, 2'd3, 32'h80000001, 1'b1};
    foreach (vecs[n]) begin
      cycle(1'b1, vecs[n].d, vecs[n].a, vecs[n].o, 1'b1);
      total++;
      if (s_acc !== 1'b1) begin
        bad++;
        $display("FAIL basic_accept[%0d]: in_ready=%0b want 1", n, s_in_ready);
      end
      for (int j = 0; j <= SHW; j++) begin
        idle(1'b1);
        total++;
        if (s_out_valid !== (j == SHW - 1)) begin
          bad++;
          $display("FAIL basic_latency[%0d]: %0d edges after accept out_valid=%0b want %0b",
                   n, j, s_out_valid, (j == SHW - 1));
        end
        if (s_fire) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          total++;
          if ({s_out_data, s_out_carry, s_out_zero} !== {vecs[n].r, vecs[n].c, vecs[n].r == '0}) begin
            bad++;
            $display("FAIL basic_result[%0d]: got d=%h c=%0b z=%0b want d=%h c=%0b z=%0b", n,
                     s_out_data, s_out_carry, s_out_zero, vecs[n].r, vecs[n].c, vecs[n].r == '0);
          end
        end
      end
    end
  endtask

  task automatic test_throughput;
    int   first = -1;
    int   last  = -1;
    int   got   = 0;
    res_t e;
    exp_q.delete();
    for (int cyc = 0; cyc < 300 && got < 100; cyc++) begin
      if (cyc < 100) begin
        rand_op(1'b1);
        total++;
        if (s_in_ready !== 1'b1) begin
          bad++;
          $display("FAIL thru_in_ready: cycle %0d got %0b want 1", cyc, s_in_ready);
        end
      end else begin
        idle(1'b1);
      end
      if (s_fire) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL thru_extra: unexpected result d=%h", s_out_data);
        end else begin
          e = exp_q.pop_front();
          if ({s_out_data, s_out_carry, s_out_zero} !== e) begin
            bad++;
            $display("FAIL thru_result[%0d]: got %h/%0b/%0b want %h/%0b/%0b", got,
                     s_out_data, s_out_carry, s_out_zero, e.data, e.carry, e.zero);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
    end
    total++;
    if (got != 100 || last - first != 99) begin
      bad++;
      $display("FAIL thru_rate: got %0d results over %0d cycles want 100 over 100",
               got, last - first + 1);
    end
  endtask

  task automatic test_backpressure;
    int   sent  = 0;
    int   got   = 0;
    logic stall = 1'b0;
    res_t prev  = '0;
    res_t e;
    logic v, r;
    exp_q.delete();
    for (int cyc = 0; cyc < 40000 && got < 2000; cyc++) begin
      v = (sent < 2000) && ($urandom_range(1) == 1);
      r = ($urandom_range(1) == 1);
      cycle(v, $urandom, SHW'($urandom), 2'($urandom), r);
      if (s_acc) sent++;
      if (stall) begin
        total++;
        if (s_out_valid !== 1'b1 || {s_out_data, s_out_carry, s_out_zero} !== prev) begin
          bad++;
          $display("FAIL bp_stable: cycle %0d got v=%0b %h/%0b/%0b want v=1 %h/%0b/%0b", cyc,
                   s_out_valid, s_out_data, s_out_carry, s_out_zero, prev.data, prev.carry, prev.zero);
        end
      end
      stall = s_out_valid && !r;
      prev  = {s_out_data, s_out_carry, s_out_zero};
      if (s_fire) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL bp_extra: unexpected result d=%h", s_out_data);
        end else begin
          e = exp_q.pop_front();
          if ({s_out_data, s_out_carry, s_out_zero} !== e) begin
            bad++;
            $display("FAIL bp_result[%0d]: got %h/%0b/%0b want %h/%0b/%0b", got,
                     s_out_data, s_out_carry, s_out_zero, e.data, e.carry, e.zero);
          end
        end
        got++;
      end
    end
    total++;
    if (got != 2000 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_count: got %0d results, %0d pending, want 2000 and 0", got, exp_q.size());
    end

    // Fill the pipe with the output blocked, then stream through it full.
    exp_q.delete();
    for (int i = 0; i < SHW; i++) begin
      rand_op(1'b0);
      total++;
      if (s_acc !== 1'b1) begin
        bad++;
        $display("FAIL fill_accept[%0d]: in_ready=%0b want 1", i, s_in_ready);
      end
    end
    rand_op(1'b0);
    total++;
    if (s_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_in_ready: got %0b want 0", s_in_ready);
    end
    for (int i = 0; i < SHW + 8 && (i < SHW || exp_q.size() > 0); i++) begin
      if (i < SHW) begin
        rand_op(1'b1);
        total++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b1) begin
          bad++;
          $display("FAIL full_stream[%0d]: in_ready=%0b out_valid=%0b want 1/1",
                   i, s_in_ready, s_out_valid);
        end
      end else begin
        idle(1'b1);
      end
      if (s_fire) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL full_extra: unexpected result d=%h", s_out_data);
        end else begin
          e = exp_q.pop_front();
          if ({s_out_data, s_out_carry, s_out_zero} !== e) begin
            bad++;
            $display("FAIL full_result[%0d]: got %h/%0b/%0b want %h/%0b/%0b", i,
                     s_out_data, s_out_carry, s_out_zero, e.data, e.carry, e.zero);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL full_drain: %0d results never emerged, want 0", exp_q.size());
    end
  endtask

  task automatic test_bubble;
    res_t e;
    exp_q.delete();
    rand_op(1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0);
    rand_op(1'b0);
    total++;
    if (exp_q.size() != 2) begin
      bad++;
      $display("FAIL bubble_accept: accepted %0d want 2", exp_q.size());
    end
    for (int i = 0; i < 4; i++) idle(1'b0);
    for (int i = 0; i < 2; i++) begin
      idle(1'b1);
      total++;
      if (s_fire !== 1'b1 || exp_q.size() == 0) begin
        bad++;
        $display("FAIL bubble_consecutive[%0d]: out_valid=%0b want 1", i, s_out_valid);
      end else begin
        e = exp_q.pop_front();
        if ({s_out_data, s_out_carry, s_out_zero} !== e) begin
          bad++;
          $display("FAIL bubble_result[%0d]: got %h/%0b/%0b want %h/%0b/%0b", i,
                   s_out_data, s_out_carry, s_out_zero, e.data, e.carry, e.zero);
        end
      end
    end
    idle(1'b1);
    total++;
    if (s_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bubble_tail: out_valid=%0b want 0", s_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_throughput();
    test_backpressure();
    test_bubble();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
